// File: rtl/seg_pkg.sv
// Shared glyph encodings and scan FSM states for the 7-segment scan bus decoder.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4f;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4c;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0f;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;
    localparam logic [6:0] SEG_BLANK = 7'h7f;

    // Entry k is the active-low glyph for BCD value k.
    localparam logic [9:0][6:0] GLYPH_TBL = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                             SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

    typedef enum logic {SEARCH, COLLECT} scan_state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Active-low 7-segment pattern -> {legal digit, blank, bcd}.
module seg7_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       legal,
    output logic       blank,
    output logic [3:0] bcd
);

    always_comb begin
        legal = 1'b0;
        blank = (pattern == SEG_BLANK);
        bcd   = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (pattern == GLYPH_TBL[k]) begin
                legal = 1'b1;
                bcd   = 4'(k);
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Scan-bus readback: synchronise, settle, decode, reassemble and atomically commit frames.
// Optional blink detection per digit is built when BLINK_DETECT_EN is defined.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int SETTLE_CYC = 4,
    parameter int BLINK_HOLD = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     seg_sel,
    input  logic [6:0]            segment,
    output logic [DIGITS*4-1:0]   digit_val,
    output logic [DIGITS-1:0]     digit_blank,
    output logic [DIGITS-1:0]     digit_blink,
    output logic                  frame_vld,
    output logic                  code_err,
    output logic                  seq_err
);

    localparam int SW    = DIGITS + 7;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW    = $clog2(SETTLE_CYC);

    logic [SW-1:0]  sync1, sync2, samp_q;
    logic [CW-1:0]  stab_cnt;
    logic           change, capture;

    // Reset to "display off" so the idle bus never looks like a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '1;
            sync2  <= '1;
            samp_q <= '1;
        end else begin
            sync1  <= {seg_sel, segment};
            sync2  <= sync1;
            samp_q <= sync2;
        end
    end

    assign change  = (sync2 != samp_q);
    assign capture = !change && (stab_cnt == CW'(SETTLE_CYC - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               stab_cnt <= '0;
        else if (change)                          stab_cnt <= '0;
        else if (stab_cnt != CW'(SETTLE_CYC - 1)) stab_cnt <= stab_cnt + 1'b1;
    end

    logic [DIGITS-1:0] lows;
    logic              sel_none, sel_one;
    logic [IDX_W-1:0]  idx;
    logic              g_legal, g_blank;
    logic [3:0]        g_bcd;

    assign lows     = ~sync2[SW-1:7];
    assign sel_none = (lows == '0);
    assign sel_one  = !sel_none && ((lows & (lows - 1'b1)) == '0);

    always_comb begin
        idx = '0;
        for (int k = 0; k < DIGITS; k++)
            if (lows[k]) idx = IDX_W'(k);
    end

    seg7_glyph_decode u_dec (
        .pattern (sync2[6:0]),
        .legal   (g_legal),
        .blank   (g_blank),
        .bcd     (g_bcd)
    );

    scan_state_t                state, state_nxt;
    logic [IDX_W-1:0]           exp_idx, exp_nxt;
    logic [DIGITS-1:0][3:0]     shadow_val, sv_nxt, val_q;
    logic [DIGITS-1:0]          shadow_blank, sb_nxt, blank_q;
    logic                       commit, code_err_d, seq_err_d;

    always_comb begin
        state_nxt  = state;
        exp_nxt    = exp_idx;
        sv_nxt     = shadow_val;
        sb_nxt     = shadow_blank;
        commit     = 1'b0;
        code_err_d = 1'b0;
        seq_err_d  = 1'b0;
        if (capture && !sel_none) begin
            if (!sel_one) begin
                seq_err_d = 1'b1;
                state_nxt = SEARCH;
            end else if (!g_legal && !g_blank) begin
                code_err_d = 1'b1;
                state_nxt  = SEARCH;
            end else begin
                if (g_blank) begin
                    sb_nxt[idx] = 1'b1;
                end else begin
                    sv_nxt[idx] = g_bcd;
                    sb_nxt[idx] = 1'b0;
                end
                // Index 0 always (re)starts a frame, even mid-collect.
                if (idx == '0) begin
                    state_nxt = COLLECT;
                    exp_nxt   = IDX_W'(1);
                end else if (state == COLLECT) begin
                    if (idx == exp_idx) begin
                        if (idx == IDX_W'(DIGITS - 1)) begin
                            commit    = 1'b1;
                            state_nxt = SEARCH;
                        end else begin
                            exp_nxt = exp_idx + 1'b1;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        state_nxt = SEARCH;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SEARCH;
            exp_idx      <= '0;
            shadow_val   <= '0;
            shadow_blank <= '1;
            val_q        <= '0;
            blank_q      <= '1;
            frame_vld    <= 1'b0;
            code_err     <= 1'b0;
            seq_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            exp_idx      <= exp_nxt;
            shadow_val   <= sv_nxt;
            shadow_blank <= sb_nxt;
            frame_vld    <= commit;
            code_err     <= code_err_d;
            seq_err      <= seq_err_d;
            // Commit from next-state shadow so the final digit lands in the same frame.
            if (commit) begin
                val_q   <= sv_nxt;
                blank_q <= sb_nxt;
            end
        end
    end

    assign digit_val   = val_q;
    assign digit_blank = blank_q;

`ifdef BLINK_DETECT_EN
    localparam int BW = $clog2(BLINK_HOLD + 1);
    logic [DIGITS-1:0][BW-1:0] blink_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
        end else if (commit) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (sb_nxt[i] != blank_q[i]) blink_cnt[i] <= BW'(BLINK_HOLD);
                else if (blink_cnt[i] != '0) blink_cnt[i] <= blink_cnt[i] - 1'b1;
            end
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_blink
        assign digit_blink[i] = |blink_cnt[i];
    end
`else
    assign digit_blink = '0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: frames, settle filter, errors, blink, async reset.
module tb_seg_scan_decoder;

    localparam logic [6:0] G0 = 7'h01, G1 = 7'h4f, G2 = 7'h12, G3 = 7'h06, G4 = 7'h4c;
    localparam logic [6:0] G5 = 7'h24, G6 = 7'h20, G7 = 7'h0f, G8 = 7'h00, G9 = 7'h04;
    localparam logic [6:0] GB = 7'h7f;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg_sel;
    logic [6:0]  segment;
    logic [31:0] digit_val;
    logic [7:0]  digit_blank, digit_blink;
    logic        frame_vld, code_err, seq_err;

    int checks = 0, failures = 0;
    int n_fv = 0, n_ce = 0, n_se = 0, n_both = 0;
    int fv0, ce0, se0;
    logic [7:0] blink_on;

    seg_scan_decoder #(.DIGITS(8), .SETTLE_CYC(4), .BLINK_HOLD(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_sel     (seg_sel),
        .segment     (segment),
        .digit_val   (digit_val),
        .digit_blank (digit_blank),
        .digit_blink (digit_blink),
        .frame_vld   (frame_vld),
        .code_err    (code_err),
        .seq_err     (seq_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_vld) n_fv++;
        if (code_err) n_ce++;
        if (seq_err) n_se++;
        if (code_err && seq_err) n_both++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic show(input int idx, input logic [6:0] pat, input int n);
        seg_sel = (idx < 0) ? 8'hff : ~(8'h01 << idx);
        segment = pat;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0][6:0] g, input int gap);
        for (int k = 0; k < 8; k++) begin
            show(k, g[k], 20);
            if (gap > 0) show(-1, GB, gap);
        end
        show(-1, GB, 10);
    endtask

    task automatic snap();
        fv0 = n_fv;
        ce0 = n_ce;
        se0 = n_se;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef BLINK_DETECT_EN
        blink_on = 8'h04;
`else
        blink_on = 8'h00;
`endif
        rst_n   = 1'b0;
        seg_sel = 8'hff;
        segment = GB;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_val",   digit_val,   32'h0);
        chk("rst_blank", digit_blank, 8'hff);
        chk("rst_blink", digit_blink, 8'h00);
        chk("rst_pulses", {frame_vld, code_err, seq_err}, 3'b000);
        rst_n = 1'b1;
        show(-1, GB, 5);

        // 1: "235959" with idx0 as least significant digit
        snap();
        frame({G0, G0, G2, G3, G5, G9, G5, G9}, 0);
        chk("t1_fv",    n_fv - fv0, 1);
        chk("t1_val",   digit_val, 32'h00235959);
        chk("t1_blank", digit_blank, 8'h00);
        chk("t1_err",   (n_ce - ce0) + (n_se - se0), 0);

        // 2: idx5 glyph changes every 3 cycles, never settling
        snap();
        show(0, G1, 20); show(1, G2, 20); show(2, G3, 20); show(3, G4, 20); show(4, G5, 20);
        for (int r = 0; r < 7; r++) show(5, (r % 2) ? G7 : G1, 3);
        show(6, G6, 20); show(7, G7, 20); show(-1, GB, 10);
        chk("t2_seq", n_se - se0, 1);
        chk("t2_fv",  n_fv - fv0, 0);
        chk("t2_val", digit_val, 32'h00235959);

        // 3: illegal glyph on idx3, then a clean frame
        snap();
        frame({G0, G0, G0, G0, 7'h55, G0, G0, G0}, 0);
        chk("t3_code", n_ce - ce0, 1);
        chk("t3_seq",  n_se - se0, 0);
        chk("t3_fv",   n_fv - fv0, 0);
        chk("t3_val",  digit_val, 32'h00235959);
        snap();
        frame({G8, G7, G6, G5, G4, G3, G2, G1}, 0);
        chk("t3_fv2",  n_fv - fv0, 1);
        chk("t3_val2", digit_val, 32'h87654321);

        // 4: two selects low, then a frame with display-off gaps
        snap();
        show(-1, GB, 10);
        seg_sel = 8'b11110011; segment = G3;
        repeat (20) @(posedge clk);
        #1;
        show(-1, GB, 10);
        chk("t4_seq", n_se - se0, 1);
        snap();
        frame({G2, G3, G4, G5, G6, G7, G8, G9}, 10);
        chk("t4_err", (n_ce - ce0) + (n_se - se0), 0);
        chk("t4_fv",  n_fv - fv0, 1);
        chk("t4_val", digit_val, 32'h23456789);

        // 5: idx2 blanks on alternate frames, then stops
        frame({G1, G1, G1, G1, G1, GB, G1, G1}, 0);
        chk("t5_valA",  digit_val, 32'h11111711);
        chk("t5_blankA", digit_blank, 8'h04);
        chk("t5_blinkA", digit_blink, blink_on);
        frame({G1, G1, G1, G1, G1, G2, G1, G1}, 0);
        chk("t5_valB",  digit_val, 32'h11111211);
        chk("t5_blankB", digit_blank, 8'h00);
        frame({G1, G1, G1, G1, G1, GB, G1, G1}, 0);
        frame({G1, G1, G1, G1, G1, G2, G1, G1}, 0);
        chk("t5_blink_last", digit_blink, blink_on);
        frame({G1, G1, G1, G1, G1, G2, G1, G1}, 0);
        frame({G1, G1, G1, G1, G1, G2, G1, G1}, 0);
        chk("t5_blink_hold", digit_blink, blink_on);
        frame({G1, G1, G1, G1, G1, G2, G1, G1}, 0);
        chk("t5_blink_off", digit_blink, 8'h00);
        chk("t5_both", n_both, 0);

        // 6: async reset while idx4 is on the bus
        show(0, G3, 20); show(1, G3, 20); show(2, G3, 20); show(3, G3, 20);
        show(4, G3, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_val",   digit_val, 32'h0);
        chk("t6_blank", digit_blank, 8'hff);
        chk("t6_blink", digit_blink, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        snap();
        show(4, G3, 10); show(5, G3, 20); show(6, G3, 20); show(7, G3, 20); show(-1, GB, 10);
        chk("t6_partial", n_fv - fv0, 0);
        frame({G7, G6, G5, G4, G3, G2, G1, G0}, 0);
        chk("t6_fv",  n_fv - fv0, 1);
        chk("t6_val", digit_val, 32'h76543210);
        chk("t6_err", (n_ce - ce0) + (n_se - se0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
